// File: rtl/bob.sv
// bob: branch order buffer that records per-branch predictor state and releases it in program order at retire.
// Optional BOB_STATS_EN adds saturating retire and mispredict counters.
module bob #(
  parameter int DEPTH    = 16,
  parameter int LOGDEPTH = 4,
  parameter int BHRW     = 12,
  parameter int LHW      = 10
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                flush_i,
  input  logic                bob_alloc_i,
  input  logic [63:0]         bob_alloc_pc_i,
  input  logic [BHRW-1:0]     bob_alloc_bhr_i,
  input  logic [LHW-1:0]      bob_alloc_lochist_i,
  input  logic                bob_alloc_pred_i,
  input  logic                bob_alloc_chwe_i,
  input  logic                bob_alloc_chud_i,
  output logic                bob_full_o,
  output logic [LOGDEPTH-1:0] bob_tag_o,
  input  logic                bob_rt_valid_i,
  input  logic                bob_rt_brdir_i,
  output logic                bpd_rt_ud_o,
  output logic                bpd_rt_brdir_o,
  output logic [63:0]         bob_pc_r_o,
  output logic [BHRW-1:0]     bob_bhr_r_o,
  output logic [LHW-1:0]      bob_lochist_r_o,
  output logic                bob_ch_we_o,
  output logic                bob_ch_ud_o,
  output logic                bob_flush_o,
  output logic                bob_valid_r_o
`ifdef BOB_STATS_EN
  ,
  output logic [31:0]         bob_nret_o,
  output logic [31:0]         bob_nmisp_o
`endif
);
  typedef struct packed {
    logic [63:0]     pc;
    logic [BHRW-1:0] bhr;
    logic [LHW-1:0]  lh;
    logic            pred;
    logic            chwe;
    logic            chud;
  } ent_t;
  ent_t mem_q [DEPTH];
  ent_t wr_d, hd;
  logic [LOGDEPTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [LOGDEPTH:0] cnt_q, cnt_d;
  logic full, rt_ok, misp, kill, al_ok;
  logic ud_q, ud_d, dir_q, dir_d, chwe_q, chwe_d, chud_q, chud_d, fl_q, fl_d;
  logic [63:0] pc_q, pc_d;
  logic [BHRW-1:0] bhr_q, bhr_d;
  logic [LHW-1:0] lh_q, lh_d;
  always_comb begin
    hd     = mem_q[head_q];
    wr_d   = '{bob_alloc_pc_i, bob_alloc_bhr_i, bob_alloc_lochist_i,
               bob_alloc_pred_i, bob_alloc_chwe_i, bob_alloc_chud_i};
    full   = cnt_q == (LOGDEPTH+1)'(DEPTH);
    rt_ok  = bob_rt_valid_i & (cnt_q != '0);
    misp   = rt_ok & (bob_rt_brdir_i != hd.pred);
    kill   = flush_i | misp;
    // full is sampled before the pop, so a full buffer never accepts into the slot being freed
    al_ok  = bob_alloc_i & ~full & ~kill;
    head_d = head_q + LOGDEPTH'(rt_ok);
    tail_d = kill ? head_d : tail_q + LOGDEPTH'(al_ok);
    cnt_d  = kill ? '0 : cnt_q + (LOGDEPTH+1)'(al_ok) - (LOGDEPTH+1)'(rt_ok);
    ud_d   = rt_ok;
    dir_d  = rt_ok ? bob_rt_brdir_i : dir_q;
    pc_d   = rt_ok ? hd.pc : pc_q;
    bhr_d  = rt_ok ? hd.bhr : bhr_q;
    lh_d   = rt_ok ? hd.lh : lh_q;
    chwe_d = rt_ok ? hd.chwe : chwe_q;
    chud_d = rt_ok ? bob_rt_brdir_i ^ hd.chud : chud_q;
    fl_d   = misp;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      ud_q   <= 1'b0;
      dir_q  <= 1'b0;
      pc_q   <= '0;
      bhr_q  <= '0;
      lh_q   <= '0;
      chwe_q <= 1'b0;
      chud_q <= 1'b0;
      fl_q   <= 1'b0;
    end else begin
      if (al_ok) mem_q[tail_q] <= wr_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      ud_q   <= ud_d;
      dir_q  <= dir_d;
      pc_q   <= pc_d;
      bhr_q  <= bhr_d;
      lh_q   <= lh_d;
      chwe_q <= chwe_d;
      chud_q <= chud_d;
      fl_q   <= fl_d;
    end
  end
  assign bob_full_o      = full;
  assign bob_tag_o       = tail_q;
  assign bpd_rt_ud_o     = ud_q;
  assign bpd_rt_brdir_o  = dir_q;
  assign bob_pc_r_o      = pc_q;
  assign bob_bhr_r_o     = bhr_q;
  assign bob_lochist_r_o = lh_q;
  assign bob_ch_we_o     = ud_q & chwe_q;
  assign bob_ch_ud_o     = chud_q;
  assign bob_flush_o     = fl_q;
  assign bob_valid_r_o   = fl_q;
`ifdef BOB_STATS_EN
  logic [31:0] nret_q, nret_d, nmisp_q, nmisp_d;
  always_comb begin
    nret_d  = nret_q + 32'(rt_ok & ~&nret_q);
    nmisp_d = nmisp_q + 32'(misp & ~&nmisp_q);
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      nret_q  <= '0;
      nmisp_q <= '0;
    end else begin
      nret_q  <= nret_d;
      nmisp_q <= nmisp_d;
    end
  end
  assign bob_nret_o  = nret_q;
  assign bob_nmisp_o = nmisp_q;
`endif
endmodule

// File: tb/tb_bob.sv
// tb_bob: directed vector bench for the branch order buffer.
module tb_bob;
  logic clock = 1'b0, reset_n = 1'b0, flush_i = 1'b0;
  logic bob_alloc_i = 1'b0, bob_alloc_pred_i = 1'b0, bob_alloc_chwe_i = 1'b0, bob_alloc_chud_i = 1'b0;
  logic [63:0] bob_alloc_pc_i = '0;
  logic [11:0] bob_alloc_bhr_i = '0;
  logic [9:0] bob_alloc_lochist_i = '0;
  logic bob_rt_valid_i = 1'b0, bob_rt_brdir_i = 1'b0;
  logic bob_full_o, bpd_rt_ud_o, bpd_rt_brdir_o, bob_ch_we_o, bob_ch_ud_o, bob_flush_o, bob_valid_r_o;
  logic [3:0] bob_tag_o;
  logic [63:0] bob_pc_r_o;
  logic [11:0] bob_bhr_r_o;
  logic [9:0] bob_lochist_r_o;
`ifdef BOB_STATS_EN
  logic [31:0] bob_nret_o, bob_nmisp_o;
`endif
  int n_chk = 0, n_fail = 0, exp_ret = 0, exp_misp = 0;

  bob dut (
    .clock(clock), .reset_n(reset_n), .flush_i(flush_i),
    .bob_alloc_i(bob_alloc_i), .bob_alloc_pc_i(bob_alloc_pc_i), .bob_alloc_bhr_i(bob_alloc_bhr_i),
    .bob_alloc_lochist_i(bob_alloc_lochist_i), .bob_alloc_pred_i(bob_alloc_pred_i),
    .bob_alloc_chwe_i(bob_alloc_chwe_i), .bob_alloc_chud_i(bob_alloc_chud_i),
    .bob_full_o(bob_full_o), .bob_tag_o(bob_tag_o),
    .bob_rt_valid_i(bob_rt_valid_i), .bob_rt_brdir_i(bob_rt_brdir_i),
    .bpd_rt_ud_o(bpd_rt_ud_o), .bpd_rt_brdir_o(bpd_rt_brdir_o), .bob_pc_r_o(bob_pc_r_o),
    .bob_bhr_r_o(bob_bhr_r_o), .bob_lochist_r_o(bob_lochist_r_o),
    .bob_ch_we_o(bob_ch_we_o), .bob_ch_ud_o(bob_ch_ud_o),
    .bob_flush_o(bob_flush_o), .bob_valid_r_o(bob_valid_r_o)
`ifdef BOB_STATS_EN
    , .bob_nret_o(bob_nret_o), .bob_nmisp_o(bob_nmisp_o)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic a; logic [63:0] pc; logic pr, we, cu;
    logic rv, rd;
    logic e_ud, e_dir, e_we, e_cud, e_fl; logic [63:0] e_pc;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // inputs change 1 time unit after posedge; outputs are sampled at the same point
  task automatic cyc(input logic a, input logic [63:0] pc, input logic [11:0] bhr, input logic [9:0] lh,
                     input logic pr, input logic we, input logic cu,
                     input logic rv, input logic rd, input logic fl);
    bob_alloc_i = a; bob_alloc_pc_i = pc; bob_alloc_bhr_i = bhr; bob_alloc_lochist_i = lh;
    bob_alloc_pred_i = pr; bob_alloc_chwe_i = we; bob_alloc_chud_i = cu;
    bob_rt_valid_i = rv; bob_rt_brdir_i = rd; flush_i = fl;
    @(posedge clock); #1;
    bob_alloc_i = 1'b0; bob_rt_valid_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic alloc(input logic [63:0] pc, input logic pr);
    cyc(1'b1, pc, pc[11:0], pc[9:0], pr, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic retire(input logic rd);
    cyc(1'b0, 64'h0, 12'h0, 10'h0, 1'b0, 1'b0, 1'b0, 1'b1, rd, 1'b0);
  endtask

  task automatic ret_chk(input string nm, input logic eu, input logic [63:0] epc, input logic efl);
    chk({nm, ".ud"}, 64'(bpd_rt_ud_o), 64'(eu));
    if (eu) chk({nm, ".pc"}, bob_pc_r_o, epc);
    chk({nm, ".flush"}, 64'(bob_flush_o), 64'(efl));
    chk({nm, ".valid_r"}, 64'(bob_valid_r_o), 64'(efl));
    if (eu) exp_ret++;
    if (efl) exp_misp++;
  endtask

  task automatic zero_chk(input string nm);
    chk({nm, ".ud"}, 64'(bpd_rt_ud_o), 0);
    chk({nm, ".pc"}, bob_pc_r_o, 0);
    chk({nm, ".bhr"}, 64'(bob_bhr_r_o), 0);
    chk({nm, ".full"}, 64'(bob_full_o), 0);
    chk({nm, ".tag"}, 64'(bob_tag_o), 0);
    chk({nm, ".flush"}, 64'(bob_flush_o | bob_valid_r_o | bob_ch_we_o | bob_ch_ud_o | bpd_rt_brdir_o), 0);
  endtask

  initial begin
    tbl[0] = '{1'b1, 64'h6000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0};
    tbl[1] = '{1'b1, 64'h6004, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0};
    tbl[2] = '{1'b1, 64'h6008, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0};
    tbl[3] = '{1'b0, 64'h0,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 64'h6000};
    tbl[4] = '{1'b0, 64'h0,    1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'h6004};
    tbl[5] = '{1'b0, 64'h0,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 64'h6008};
    tbl[6] = '{1'b0, 64'h0,    1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0};

    // reset, then a mid-burst asynchronous reset
    repeat (2) @(posedge clock);
    #1 zero_chk("reset");
    reset_n = 1'b1;
    alloc(64'h100, 1'b1);
    alloc(64'h104, 1'b1);
    retire(1'b1);
    chk("pre_rst.ud", 64'(bpd_rt_ud_o), 1);
    chk("pre_rst.pc", bob_pc_r_o, 64'h100);
    #2 reset_n = 1'b0;
    #1 zero_chk("async_rst");
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1;
    retire(1'b1);
    ret_chk("rst_empty_rt", 1'b0, 64'h0, 1'b0);

    // fill to full, dropped 17th alloc, in-order drain
    for (int i = 0; i < 16; i++) begin
      alloc(64'h1000 + 64'(4 * i), 1'b1);
      chk("fill.tag", 64'(bob_tag_o), 64'((i + 1) % 16));
      chk("fill.full", 64'(bob_full_o), 64'(i == 15));
    end
    alloc(64'hDEAD, 1'b0);
    chk("drop.full", 64'(bob_full_o), 1);
    chk("drop.tag", 64'(bob_tag_o), 0);
    for (int i = 0; i < 16; i++) begin
      retire(1'b1);
      ret_chk("drain", 1'b1, 64'h1000 + 64'(4 * i), 1'b0);
    end
    chk("drain.full", 64'(bob_full_o), 0);

    // mispredict repair discards younger entries
    cyc(1'b1, 64'h2000, 12'h0A5, 10'h155, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    alloc(64'h2004, 1'b1);
    retire(1'b0);
    ret_chk("misp", 1'b1, 64'h2000, 1'b1);
    chk("misp.bhr", 64'(bob_bhr_r_o), 64'h0A5);
    chk("misp.lh", 64'(bob_lochist_r_o), 64'h155);
    chk("misp.dir", 64'(bpd_rt_brdir_o), 0);
    chk("misp.tag", 64'(bob_tag_o), 1);
    retire(1'b1);
    ret_chk("misp_gone", 1'b0, 64'h0, 1'b0);
    chk("misp_hold.bhr", 64'(bob_bhr_r_o), 64'h0A5);

    // pointer wrap
    for (int i = 0; i < 10; i++) alloc(64'h4000 + 64'(4 * i), 1'b0);
    for (int i = 0; i < 10; i++) begin
      retire(1'b0);
      ret_chk("wrap_a", 1'b1, 64'h4000 + 64'(4 * i), 1'b0);
    end
    for (int i = 0; i < 12; i++) alloc(64'h4100 + 64'(4 * i), 1'b1);
    for (int i = 0; i < 12; i++) begin
      retire(1'b1);
      ret_chk("wrap_b", 1'b1, 64'h4100 + 64'(4 * i), 1'b0);
    end

    // simultaneous alloc+retire keeps count at 5, then flush with retire
    for (int i = 0; i < 5; i++) alloc(64'h5000 + 64'(4 * i), 1'b1);
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, 64'h5000 + 64'(4 * (5 + k)), 12'h0, 10'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      ret_chk("simul", 1'b1, 64'h5000 + 64'(4 * k), 1'b0);
    end
    for (int i = 0; i < 11; i++) begin
      alloc(64'h5800 + 64'(4 * i), 1'b1);
      chk("simul.full", 64'(bob_full_o), 64'(i == 10));
    end
    cyc(1'b1, 64'hBEEF, 12'h0, 10'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    ret_chk("flush_rt", 1'b1, 64'h5020, 1'b0);
    chk("flush.full", 64'(bob_full_o), 0);
    retire(1'b1);
    ret_chk("flush_empty", 1'b0, 64'h0, 1'b0);

    // choice-table update vectors
    for (int i = 0; i < 7; i++) begin
      cyc(tbl[i].a, tbl[i].pc, 12'h0, 10'h0, tbl[i].pr, tbl[i].we, tbl[i].cu, tbl[i].rv, tbl[i].rd, 1'b0);
      ret_chk($sformatf("choice%0d", i), tbl[i].e_ud, tbl[i].e_pc, tbl[i].e_fl);
      chk($sformatf("choice%0d.we", i), 64'(bob_ch_we_o), 64'(tbl[i].e_we));
      if (tbl[i].e_ud) begin
        chk($sformatf("choice%0d.dir", i), 64'(bpd_rt_brdir_o), 64'(tbl[i].e_dir));
        chk($sformatf("choice%0d.cud", i), 64'(bob_ch_ud_o), 64'(tbl[i].e_cud));
      end
    end

`ifdef BOB_STATS_EN
    chk("stats.nret", 64'(bob_nret_o), 64'(exp_ret));
    chk("stats.nmisp", 64'(bob_nmisp_o), 64'(exp_misp));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
